// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock through an IDLE/SHIFT/DONE FSM.
// Latency: N SHIFT cycles after the accepting edge, then one DONE cycle; start is ignored (not queued) while busy or done.
module n_bit_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_br;
    logic [N-1:0]  r_res;
    logic [CW-1:0] r_cnt;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [N-1:0]  r_diff;
    logic          r_borrow_out;
    logic          r_overflow;

    logic          w_d;
    logic          w_br_nxt;
    logic          w_last;
    logic [N-1:0]  w_res_nxt;

    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_res_nxt = {w_d, r_res[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_br         <= 1'b0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= borrow_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_a_msb <= a[N-1];
                        r_b_msb <= b[N-1];
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_res <= w_res_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // On the final bit w_d is the result MSB, so results are published here.
                    if (w_last) begin
                        r_diff       <= w_res_nxt;
                        r_borrow_out <= w_br_nxt;
                        r_overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule
